// File: rtl/fetch_prefetch_pkg.sv
// fetch_prefetch_pkg: shared definitions for the instruction prefetch stage.
//   FP_ADDR_WIDTH / FP_INSTR_WIDTH : default address and instruction widths
//   INSTR_BYTES                    : byte size of one instruction (PC step)
//   NOP_BUBBLE                     : value driven to decode when nothing is queued
//   is_misaligned()                : flags a fetch target not on an instruction boundary
package fetch_prefetch_pkg;

  localparam int FP_ADDR_WIDTH  = 32;
  localparam int FP_INSTR_WIDTH = 32;
  localparam int INSTR_BYTES    = 4;
  localparam int NOP_BUBBLE     = 0;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// fetch_prefetch_fifo: synchronous queue of {pc, instr} pairs between imem and decode.
//   cpu_clk, cpu_rstn       : clock, asynchronous active-low reset
//   push, push_pc/instr     : enqueue one entry (ignored when full)
//   pop                     : dequeue head (ignored when empty)
//   flush                   : empty the queue; wins over push/pop
//   head_valid/pc/instr     : head entry, read combinationally from storage
//   count                   : number of queued entries
// DEPTH must be a power of two so the pointers wrap without compare logic.
module fetch_prefetch_fifo #(
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rstn,
  input  logic                       push,
  input  logic [AW-1:0]              push_pc,
  input  logic [IW-1:0]              push_instr,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       head_valid,
  output logic [AW-1:0]              head_pc,
  output logic [IW-1:0]              head_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] pc_mem    [DEPTH];
  logic [IW-1:0] instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~flush & (cnt != CW'(DEPTH));
  assign do_pop  = pop  & ~flush & (cnt != '0);

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (!do_push && do_pop) cnt <= cnt - CW'(1);
    end
  end

  // storage carries no reset: only entries covered by cnt are ever observed
  always_ff @(posedge cpu_clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign head_valid = (cnt != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];
  assign count      = cnt;

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction fetch with a DEPTH-entry prefetch queue and up to
// MAX_OUTST pipelined imem requests.
//   cpu_clk, cpu_rstn            : clock, asynchronous active-low reset
//   boot_addr                    : first fetch address after reset
//   redirect, redirect_pc        : flush and restart fetch at a resolved target
//   halt                         : debug halt, blocks new requests only
//   imem_req/addr/gnt            : request channel to imem_ctrl
//   imem_rvalid/rdata            : in-order response channel from imem_ctrl
//   if_valid/instr_dec/pc_dec    : queue head to decode, dec_ready consumes it
//   pc_misaligned, fault_pc      : last redirect target was misaligned
//   occupancy                    : queued entries
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = FP_ADDR_WIDTH,
  parameter int INSTR_WIDTH = FP_INSTR_WIDTH,
  parameter int DEPTH       = 4,
  parameter int MAX_OUTST   = 2
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rstn,
  input  logic [ADDR_WIDTH-1:0]      boot_addr,
  input  logic                       redirect,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  input  logic                       halt,
  output logic                       imem_req,
  output logic [ADDR_WIDTH-1:0]      imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [INSTR_WIDTH-1:0]     imem_rdata,
  output logic                       if_valid,
  output logic [INSTR_WIDTH-1:0]     instr_dec,
  output logic [ADDR_WIDTH-1:0]      pc_dec,
  input  logic                       dec_ready,
  output logic                       pc_misaligned,
  output logic [ADDR_WIDTH-1:0]      fault_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTST+1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSTR_BYTES);

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  rsp_pc;
  logic                   fetch_boot;
  logic                   rsp_boot;
  logic [ADDR_WIDTH-1:0]  fetch_pc_cur;
  logic [ADDR_WIDTH-1:0]  rsp_pc_cur;
  logic [OW-1:0]          outst;
  logic [OW-1:0]          outst_nxt;
  logic [OW-1:0]          drop_cnt;
  logic                   misaligned;
  logic [ADDR_WIDTH-1:0]  fault_pc_q;
  logic [CW-1:0]          count;
  logic                   credit_ok;
  logic                   gnt_fire;
  logic                   rsp_take;
  logic                   push;
  logic                   pop;
  logic                   fifo_valid;
  logic [ADDR_WIDTH-1:0]  head_pc;
  logic [INSTR_WIDTH-1:0] head_instr;

  // PCs reset to a constant and follow boot_addr through a flag, so the
  // asynchronous reset never has to load a non-constant value.
  assign fetch_pc_cur = fetch_boot ? boot_addr : fetch_pc;
  assign rsp_pc_cur   = rsp_boot   ? boot_addr : rsp_pc;

  // Every granted request reserves a queue slot, so pushes never overflow.
  assign credit_ok = (32'(count) + 32'(outst)) < 32'(DEPTH);
  assign imem_req  = cpu_rstn & ~redirect & ~halt & ~misaligned
                   & (32'(outst) < 32'(MAX_OUTST)) & credit_ok;
  assign imem_addr = fetch_pc_cur;
  assign gnt_fire  = imem_req & imem_gnt;

  // A response with nothing outstanding is outside contract; ignoring it
  // keeps the credit counter from wrapping.
  assign rsp_take  = imem_rvalid & (outst != '0);
  assign push      = rsp_take & (drop_cnt == '0) & ~redirect;
  assign pop       = fifo_valid & dec_ready & ~redirect;

  always_comb begin
    outst_nxt = outst;
    if (gnt_fire) outst_nxt = outst_nxt + OW'(1);
    if (rsp_take) outst_nxt = outst_nxt - OW'(1);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      fetch_pc   <= '0;
      rsp_pc     <= '0;
      fetch_boot <= 1'b1;
      rsp_boot   <= 1'b1;
      outst      <= '0;
      drop_cnt   <= '0;
      misaligned <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      outst <= outst_nxt;
      if (redirect) begin
        fetch_pc   <= redirect_pc;
        rsp_pc     <= redirect_pc;
        fetch_boot <= 1'b0;
        rsp_boot   <= 1'b0;
        // whatever is still in flight after this cycle belongs to the old path
        drop_cnt   <= outst_nxt;
        misaligned <= is_misaligned(redirect_pc[1:0]);
        fault_pc_q <= is_misaligned(redirect_pc[1:0]) ? redirect_pc : '0;
      end else begin
        if (gnt_fire) begin
          fetch_pc   <= fetch_pc_cur + PC_STEP;
          fetch_boot <= 1'b0;
        end
        if (push) begin
          rsp_pc   <= rsp_pc_cur + PC_STEP;
          rsp_boot <= 1'b0;
        end
        if (rsp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  fetch_prefetch_fifo #(
    .AW    (ADDR_WIDTH),
    .IW    (INSTR_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .push       (push),
    .push_pc    (rsp_pc_cur),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (redirect),
    .head_valid (fifo_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count)
  );

  assign if_valid      = fifo_valid;
  assign instr_dec     = fifo_valid ? head_instr : INSTR_WIDTH'(NOP_BUBBLE);
  assign pc_dec        = fifo_valid ? head_pc : rsp_pc_cur;
  assign pc_misaligned = misaligned;
  assign fault_pc      = fault_pc_q;
  assign occupancy     = count;

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: scoreboard bench for fetch_prefetch with a latency-programmable
// in-order memory model and an expected instruction stream rebuilt on every
// reset/redirect.
module tb_fetch_prefetch;

  localparam int AW        = 32;
  localparam int IW        = 32;
  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic                       cpu_clk = 1'b0;
  logic                       cpu_rstn = 1'b0;
  logic [AW-1:0]              boot_addr;
  logic                       redirect;
  logic [AW-1:0]              redirect_pc;
  logic                       halt;
  logic                       imem_req;
  logic [AW-1:0]              imem_addr;
  logic                       imem_gnt;
  logic                       imem_rvalid;
  logic [IW-1:0]              imem_rdata;
  logic                       if_valid;
  logic [IW-1:0]              instr_dec;
  logic [AW-1:0]              pc_dec;
  logic                       dec_ready;
  logic                       pc_misaligned;
  logic [AW-1:0]              fault_pc;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  always #5 cpu_clk = ~cpu_clk;

  fetch_prefetch #(
    .ADDR_WIDTH  (AW),
    .INSTR_WIDTH (IW),
    .DEPTH       (DEPTH),
    .MAX_OUTST   (MAX_OUTST)
  ) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rstn      (cpu_rstn),
    .boot_addr     (boot_addr),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .instr_dec     (instr_dec),
    .pc_dec        (pc_dec),
    .dec_ready     (dec_ready),
    .pc_misaligned (pc_misaligned),
    .fault_pc      (fault_pc),
    .occupancy     (occupancy)
  );

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_rand = 0;
  bit          rdy_rand = 0;
  bit          rdy_hold = 1;
  bit          halt_v = 0;
  bit          redir_go = 0;
  logic [31:0] redir_tgt = '0;
  int          pops = 0;
  int          step_no = 0;
  int          first_valid = 0;
  logic [31:0] last_gnt = '0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic fill_exp(input logic [31:0] base);
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < 400; k++) begin
      e.pc    = base + 32'(4 * k);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // One cycle: drive inputs for the coming edge, then sample what that edge will do.
  task automatic body();
    pend_t p;
    exp_t  e;
    step_no++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      p = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(p.addr);
    end
    imem_gnt    = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    dec_ready   = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_hold;
    halt        = halt_v;
    redirect    = redir_go;
    redirect_pc = redir_tgt;
    #1;
    if (imem_req && imem_gnt) begin
      p.addr = imem_addr;
      p.due  = cyc + 1 + lat;
      pend.push_back(p);
      last_gnt = imem_addr;
    end
    if (if_valid && first_valid == 0) first_valid = step_no;
    if (redirect) begin
      chk("redir_no_req", imem_req, 0);
      if (redir_tgt[1:0] == 2'b00) fill_exp(redir_tgt);
      else exp_q.delete();
    end else if (if_valid && dec_ready) begin
      pops++;
      if (exp_q.size() == 0) chk("unexpected_pop", if_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("pop_pc", pc_dec, e.pc);
        chk("pop_instr", instr_dec, e.instr);
      end
    end
    redir_go = 1'b0;
  endtask

  task automatic step();
    @(negedge cpu_clk);
    body();
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redir_tgt = tgt;
    redir_go  = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vcnt;
    int p0;
    int k;
    logic [31:0] lg;
    logic [31:0] r;

    boot_addr   = 32'h8000_0000;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    dec_ready   = 1'b0;

    repeat (2) @(negedge cpu_clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 32'h8000_0000);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_instr_dec", instr_dec, 0);
    chk("rst_pc_dec", pc_dec, 32'h8000_0000);
    chk("rst_misaligned", pc_misaligned, 0);
    chk("rst_fault_pc", fault_pc, 0);
    chk("rst_occupancy", occupancy, 0);

    // release reset and stream with an always-ready decoder
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    fill_exp(boot_addr);
    rdy_hold = 1;
    body();
    for (int i = 0; i < 10; i++) step();
    chk("first_valid_step", first_valid, 3);

    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if_valid) vcnt++;
    end
    chk("throughput", vcnt, 8);

    // decoder stall fills the queue
    rdy_hold = 0;
    for (int i = 0; i < 10; i++) step();
    chk("stall_occupancy", occupancy, 4);
    chk("stall_no_req", imem_req, 0);
    rdy_hold = 1;
    for (int i = 0; i < 12; i++) step();

    // redirect with two requests in flight
    lat = 3;
    k = 0;
    do begin
      step();
      k++;
    end while (pend.size() != 2 && k < 20);
    chk("two_outstanding", pend.size(), 2);
    do_redirect(32'h0000_0100);
    step();
    chk("redir_if_valid", if_valid, 0);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    lat = 1;
    p0 = pops;
    for (int i = 0; i < 15; i++) step();
    chk("redir_resumed", (pops - p0) > 3, 1);

    // misaligned target blocks fetch until an aligned redirect
    do_redirect(32'h0000_0102);
    step();
    chk("mis_flag", pc_misaligned, 1);
    chk("mis_fault_pc", fault_pc, 32'h0000_0102);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mis_no_req", imem_req, 0);
    end
    do_redirect(32'h0000_0200);
    step();
    chk("mis_clear", pc_misaligned, 0);
    chk("mis_fault_clear", fault_pc, 0);
    chk("mis_new_addr", imem_addr, 32'h0000_0200);
    for (int i = 0; i < 10; i++) step();

    // halt with one request in flight
    lat = 2;
    k = 0;
    do begin
      step();
      k++;
    end while (pend.size() != 1 && k < 20);
    chk("one_outstanding", pend.size(), 1);
    halt_v = 1;
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_no_req", imem_req, 0);
    end
    chk("halt_drained", pend.size(), 0);
    chk("halt_pops", (pops - p0) >= 1, 1);
    lg = last_gnt;
    halt_v = 0;
    step();
    chk("halt_resume_addr", imem_addr, lg + 32'd4);
    for (int i = 0; i < 10; i++) step();

    // redirect while a response arrives and the head is popped
    lat = 1;
    for (int i = 0; i < 6; i++) step();
    do_redirect(32'h0000_0300);
    step();
    chk("rvp_if_valid", if_valid, 0);
    chk("rvp_occupancy", occupancy, 0);
    for (int i = 0; i < 10; i++) step();

    // PC wrap at the top of the address space
    do_redirect(32'hFFFF_FFF8);
    for (int i = 0; i < 10; i++) step();

    // random grant, ready, latency and redirects
    gnt_rand = 1;
    rdy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      if (i % 30 == 0) lat = $urandom_range(1, 3);
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom;
        r[1:0] = 2'b00;
        do_redirect(r);
      end else begin
        step();
      end
    end
    gnt_rand = 0;
    rdy_rand = 0;
    rdy_hold = 1;
    for (int i = 0; i < 10; i++) step();
    chk("total_pops", pops > 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised successor to the single-entry instruction fetch stage: decouples instruction memory from decode with a DEPTH-entry prefetch queue and up to MAX_OUTST pipelined imem requests. Sits between imem_ctrl and dec. Takes one pre-resolved redirect (trap/branch/jal/jalr/mret/dret target, already prioritised upstream), discards stale in-flight responses after a redirect, and flags misaligned redirect targets to trap_ctrl.

## Interface
Parameters:
- ADDR_WIDTH, 32, address/PC width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, >= 2
- MAX_OUTST, 2, maximum granted-but-unanswered imem requests; 1..DEPTH

Ports:
- cpu_clk  in  1  cpu clock
- cpu_rstn  in  1  reset, asynchronous, active-low
- boot_addr  in  ADDR_WIDTH  fetch start address after reset
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch target
- halt  in  1  debug halt; blocks new imem requests
- imem_req  out  1  request valid
- imem_addr  out  ADDR_WIDTH  request address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid (in order)
- imem_rdata  in  INSTR_WIDTH  response instruction
- if_valid  out  1  queue head valid to dec
- instr_dec  out  INSTR_WIDTH  head instruction; 0 when empty
- pc_dec  out  ADDR_WIDTH  head PC; next expected PC when empty
- dec_ready  in  1  dec consumes head when if_valid
- pc_misaligned  out  1  last redirect target misaligned
- fault_pc  out  ADDR_WIDTH  offending target; 0 otherwise
- occupancy  out  $clog2(DEPTH+1)  queued entries

## Operation
- State: fetch_pc (next request addr), rsp_pc (PC of next accepted response), outst (0..MAX_OUTST), drop_cnt (0..MAX_OUTST), queue count, misaligned flag/fault_pc.
- Request: imem_req = !redirect && !halt && !misaligned && outst < MAX_OUTST && (count + outst) < DEPTH; imem_addr = fetch_pc. On imem_req && imem_gnt: fetch_pc += 4, outst += 1. Reservation guarantees the queue can never overflow.
- Response: imem_rvalid decrements outst. If drop_cnt > 0: data discarded, drop_cnt -= 1. Else push {rsp_pc, imem_rdata}, rsp_pc += 4.
- Pop: if_valid && dec_ready. Push and pop in same cycle leave count unchanged.
- Redirect (highest priority): queue emptied, no push, no request that cycle; fetch_pc = rsp_pc = redirect_pc; drop_cnt = outst after this cycle's grant/response update, which stays counted. misaligned = |redirect_pc[1:0]; fault_pc = redirect_pc if misaligned else 0. While misaligned: no requests; cleared only by an aligned redirect.
- halt: stops new requests only; in-flight responses still pushed; pops continue.
- Arithmetic: PC increments wrap modulo 2^ADDR_WIDTH; counters never exceed bounds.

## Timing
- Reset values: imem_req 0 during reset, then per rule; imem_addr = fetch_pc = boot_addr; if_valid 0; instr_dec 0; pc_dec boot_addr; pc_misaligned 0; fault_pc 0; occupancy 0; outst, drop_cnt 0.
- Latency: grant at cycle t, rvalid at t+1 earliest, if_valid at t+2 (queue registered, no bypass).
- Throughput: one instruction per cycle sustained with MAX_OUTST >= 2, DEPTH >= 3, single-cycle memory.
- Redirect at t: imem_req 0 at t; if_valid 0 at t+1; first request for redirect_pc at t+1.
- Reset mid-operation: all state returns to reset values immediately; post-reset responses from pre-reset requests are outside contract (imem_ctrl is reset with the core).

## Structure
- Shared package (core_defines.vh): ADDR_WIDTH/INSTR_WIDTH defaults, instruction size constant 4, NOP-bubble value 0.
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr}, parameter DEPTH, push/pop/flush, count out, head read combinational from storage.
- Top holds request/credit logic, drop counter, misaligned tracking.

## Test plan
- Reset, boot_addr=0x8000_0000, always-grant 1-cycle memory, dec_ready=1 -> if_valid at cycle 3, pc_dec 0x8000_0000, 0x...04, 0x...08 on consecutive cycles.
- dec_ready=0 for 10 cycles, DEPTH=4 -> occupancy saturates at 4, imem_req 0, no lost/duplicated instructions after release.
- Redirect to 0x100 with 2 requests outstanding -> both responses dropped, next if_valid pc_dec=0x100.
- Redirect to 0x102 -> pc_misaligned=1, fault_pc=0x102, imem_req 0 until redirect to 0x200 clears it.
- halt asserted with 1 in flight -> response queued, no new requests; deassert -> fetch resumes at next sequential PC.
- Redirect same cycle as rvalid and pop -> response dropped, queue empty next cycle, drop_cnt correct.
